// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, masks and constants.
package cp0_pkg;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // CP0 register numbers
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR holds only IM[15:10], EXL[1] and IE[0]
  localparam logic [31:0] SR_WMASK     = 32'h0000_FC03;
  localparam logic [31:0] SR_EXL_BIT   = 32'h0000_0002;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE   = 32'h2024_0007;

  // M-stage exception flags, listed from highest to lowest priority
  typedef struct packed {
    logic adel_instr;
    logic ri;
    logic syscall;
    logic ov;
    logic adel_data;
    logic ades;
  } exc_flags_t;

  // Assemble the architectural Cause word from its stored fields
  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] code);
    pack_cause = {bd, 15'd0, ip, 3'd0, code, 2'd0};
  endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// M-stage to CP0 connection: pipeline drives the instruction side, CP0 answers.
interface cp0_ctrl_if;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        adel_instr_m;
  logic        ri_m;
  logic        syscall_m;
  logic        ov_m;
  logic        adel_data_m;
  logic        ades_m;
  logic        eret_m;
  logic        c0write_m;
  logic [4:0]  c0addr_m;
  logic [31:0] wdata_m;
  logic [5:0]  hwint;
  logic [31:0] rdata;
  logic [31:0] epc_out;
  logic        req;

  modport master (
    output pc_m, bd_m, adel_instr_m, ri_m, syscall_m, ov_m, adel_data_m, ades_m,
    output eret_m, c0write_m, c0addr_m, wdata_m, hwint,
    input  rdata, epc_out, req
  );

  modport slave (
    input  pc_m, bd_m, adel_instr_m, ri_m, syscall_m, ov_m, adel_data_m, ades_m,
    input  eret_m, c0write_m, c0addr_m, wdata_m, hwint,
    output rdata, epc_out, req
  );
endinterface

// File: rtl/cp0_exc_prio.sv
// Combinational ExcCode priority encoder; an enabled interrupt outranks every exception.
module cp0_exc_prio
  import cp0_pkg::*;
(
  input  logic       int_req_i,
  input  exc_flags_t flags_i,
  output logic [4:0] exc_code_o,
  output logic       exc_any_o
);

  // Pick the highest-priority pending cause
  always_comb begin
    exc_any_o  = |flags_i;
    exc_code_o = EXC_INT;
    if (int_req_i) begin
      exc_code_o = EXC_INT;
    end else if (flags_i.adel_instr) begin
      exc_code_o = EXC_ADEL;
    end else if (flags_i.ri) begin
      exc_code_o = EXC_RI;
    end else if (flags_i.syscall) begin
      exc_code_o = EXC_SYS;
    end else if (flags_i.ov) begin
      exc_code_o = EXC_OV;
    end else if (flags_i.adel_data) begin
      exc_code_o = EXC_ADEL;
    end else if (flags_i.ades) begin
      exc_code_o = EXC_ADES;
    end else begin
      exc_code_o = EXC_INT;
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 controller: SR/Cause/EPC/PRId, interrupt and exception request, ERET handling.
module cp0_ctrl
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  cp0_ctrl_if.slave   bus
);

  logic [31:0] sr_q, sr_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;

  exc_flags_t  flags_s;
  logic [4:0]  exc_code_s;
  logic        exc_any_s;
  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;

  // Gather the M-stage flags in priority order
  always_comb begin
    flags_s = '{adel_instr: bus.adel_instr_m, ri: bus.ri_m, syscall: bus.syscall_m,
                ov: bus.ov_m, adel_data: bus.adel_data_m, ades: bus.ades_m};
  end

  cp0_exc_prio u_prio (
    .int_req_i  (int_req_s),
    .flags_i    (flags_s),
    .exc_code_o (exc_code_s),
    .exc_any_o  (exc_any_s)
  );

  // Handler request: interrupts need IE and a matching IM bit, nothing is taken while EXL
  always_comb begin
    int_req_s = (|(bus.hwint & sr_q[15:10])) & sr_q[0] & ~sr_q[1];
    exc_req_s = exc_any_s & ~sr_q[1];
    req_s     = (int_req_s | exc_req_s) & ~reset;
  end

  // Next-state: taking the handler beats MTC0 and ERET; IP samples hwint every cycle
  always_comb begin
    sr_d   = sr_q;
    bd_d   = bd_q;
    ip_d   = bus.hwint;
    code_d = code_q;
    epc_d  = epc_q;
    if (req_s) begin
      sr_d   = sr_q | SR_EXL_BIT;
      bd_d   = bus.bd_m;
      code_d = exc_code_s;
      epc_d  = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
    end else begin
      if (bus.c0write_m) begin
        case (bus.c0addr_m)
          REG_SR:  sr_d  = bus.wdata_m & SR_WMASK;
          REG_EPC: epc_d = bus.wdata_m;
          default: sr_d  = sr_q;
        endcase
      end else begin
        sr_d = sr_q;
      end
      if (bus.eret_m) begin
        sr_d = sr_d & ~SR_EXL_BIT;
      end else begin
        sr_d = sr_d;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= 32'd0;
      bd_q   <= 1'b0;
      ip_q   <= 6'd0;
      code_q <= 5'd0;
      epc_q  <= 32'd0;
    end else begin
      sr_q   <= sr_d;
      bd_q   <= bd_d;
      ip_q   <= ip_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  // Register read port, showing values from before the current edge
  always_comb begin
    case (bus.c0addr_m)
      REG_SR:    bus.rdata = sr_q;
      REG_CAUSE: bus.rdata = pack_cause(bd_q, ip_q, code_q);
      REG_EPC:   bus.rdata = epc_q;
      REG_PRID:  bus.rdata = PRID_VALUE;
      default:   bus.rdata = 32'd0;
    endcase
  end

  assign bus.epc_out = epc_q;
  assign bus.req     = req_s;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed table-driven bench for cp0_ctrl plus a hand-written reset sequence.
module tb_cp0_ctrl;

  localparam logic [5:0] F_ADELI = 6'h20;
  localparam logic [5:0] F_RI    = 6'h10;
  localparam logic [5:0] F_SYS   = 6'h08;
  localparam logic [5:0] F_OV    = 6'h04;
  localparam logic [5:0] F_ADELD = 6'h02;
  localparam logic [5:0] F_ADES  = 6'h01;
  localparam logic [31:0] PRID   = 32'h2024_0007;

  typedef struct {
    logic        rst;
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [5:0]  fl;
    logic        bd;
    logic [31:0] pc;
    logic        eret;
    logic [5:0]  hw;
    logic        ereq;
    logic [31:0] erd;
    logic [31:0] eepc;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];

  cp0_ctrl_if bus();

  cp0_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic [4:0] addr, input logic wr,
                              input logic [31:0] wd, input logic [5:0] fl, input logic bd,
                              input logic [31:0] pc, input logic eret, input logic [5:0] hw,
                              input logic ereq, input logic [31:0] erd, input logic [31:0] eepc);
    vec_t v;
    v.rst = rst; v.addr = addr; v.wr = wr; v.wd = wd; v.fl = fl; v.bd = bd;
    v.pc = pc; v.eret = eret; v.hw = hw; v.ereq = ereq; v.erd = erd; v.eepc = eepc;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic [4:0] addr, input logic wr,
                       input logic [31:0] wd, input logic [5:0] fl, input logic bd,
                       input logic [31:0] pc, input logic eret, input logic [5:0] hw);
    reset            = rst;
    bus.c0addr_m     = addr;
    bus.c0write_m    = wr;
    bus.wdata_m      = wd;
    bus.adel_instr_m = fl[5];
    bus.ri_m         = fl[4];
    bus.syscall_m    = fl[3];
    bus.ov_m         = fl[2];
    bus.adel_data_m  = fl[1];
    bus.ades_m       = fl[0];
    bus.bd_m         = bd;
    bus.pc_m         = pc;
    bus.eret_m       = eret;
    bus.hwint        = hw;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    // rst addr wr wdata flags bd pc eret hwint | req rdata epc_out
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0, 5'd14, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0, 5'd15, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, PRID, 32'h0));
    tbl.push_back(mk(1'b0, 5'd0,  1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0, 32'h0));
    // MTC0 SR=0x401, then an enabled interrupt
    tbl.push_back(mk(1'b0, 5'd12, 1'b1, 32'h401, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h1000, 1'b0, 6'h01, 1'b1, 32'h401, 32'h0));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h01, 1'b0, 32'h400, 32'h1000));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h403, 32'h1000));
    tbl.push_back(mk(1'b0, 5'd14, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h1000, 32'h1000));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b1, 6'h00, 1'b0, 32'h0, 32'h1000));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h401, 32'h1000));
    // overflow in a delay slot
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, F_OV, 1'b1, 32'h3010, 1'b0, 6'h00, 1'b1, 32'h401, 32'h1000));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h80000030, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h403, 32'h300C));
    // RI+Syscall while EXL: ignored
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, F_RI | F_SYS, 1'b0, 32'h2000, 1'b0, 6'h00, 1'b0, 32'h80000030, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd14, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h300C, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h80000030, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b1, 6'h00, 1'b0, 32'h403, 32'h300C));
    // RI+Syscall with EXL clear: RI wins
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, F_RI | F_SYS, 1'b0, 32'h2000, 1'b0, 6'h00, 1'b1, 32'h401, 32'h300C));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h28, 32'h2000));
    // MTC0 EPC then ERET
    tbl.push_back(mk(1'b0, 5'd14, 1'b1, 32'h3100, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h2000, 32'h2000));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b1, 6'h00, 1'b0, 32'h403, 32'h3100));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h401, 32'h3100));
    // MTC0 SR colliding with AdEL data
    tbl.push_back(mk(1'b0, 5'd12, 1'b1, 32'hFFFFFFFF, F_ADELD, 1'b0, 32'h4000, 1'b0, 6'h00, 1'b1, 32'h401, 32'h3100));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h403, 32'h4000));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h10, 32'h4000));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b1, 6'h00, 1'b0, 32'h403, 32'h4000));
    // ERET colliding with AdES: exception wins, EXL stays set
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, F_ADES, 1'b0, 32'h5000, 1'b1, 6'h00, 1'b1, 32'h10, 32'h4000));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h403, 32'h5000));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h14, 32'h5000));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b1, 6'h00, 1'b0, 32'h403, 32'h5000));
    // AdEL instr beats Ov and AdES, delay slot
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, F_ADELI | F_OV | F_ADES, 1'b1, 32'h6000, 1'b0, 6'h00, 1'b1, 32'h401, 32'h5000));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h80000010, 32'h5FFC));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b1, 6'h00, 1'b0, 32'h403, 32'h5FFC));
    // masked interrupt line plus Syscall
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, F_SYS, 1'b0, 32'h7000, 1'b0, 6'h02, 1'b1, 32'h401, 32'h5FFC));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h820, 32'h7000));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b1, 6'h00, 1'b0, 32'h403, 32'h7000));
    // enabled interrupt beats Syscall
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, F_SYS, 1'b0, 32'h8000, 1'b0, 6'h01, 1'b1, 32'h401, 32'h7000));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h01, 1'b0, 32'h400, 32'h8000));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b1, 6'h01, 1'b0, 32'h403, 32'h8000));
    // reset with pending interrupt, exception, eret and write
    tbl.push_back(mk(1'b1, 5'd14, 1'b1, 32'h1234, F_OV, 1'b0, 32'h9000, 1'b1, 6'h01, 1'b0, 32'h8000, 32'h8000));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0, 5'd14, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0, 5'd15, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, PRID, 32'h0));
    // EPC wrap on pc=0 in a delay slot
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, F_RI, 1'b1, 32'h0, 1'b0, 6'h00, 1'b1, 32'h0, 32'h0));
    tbl.push_back(mk(1'b0, 5'd14, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h80000028, 32'hFFFFFFFC));
    // Cause is not writable; SR write under mask
    tbl.push_back(mk(1'b0, 5'd13, 1'b1, 32'hFFFFFFFF, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h80000028, 32'hFFFFFFFC));
    tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h80000028, 32'hFFFFFFFC));
    tbl.push_back(mk(1'b0, 5'd12, 1'b1, 32'hFFFFFFFF, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h2, 32'hFFFFFFFC));
    tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'hFC03, 32'hFFFFFFFC));

    drive(1'b1, 5'd0, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h00);
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].fl, tbl[i].bd,
            tbl[i].pc, tbl[i].eret, tbl[i].hw);
      #2;
      check($sformatf("row%0d req", i), {31'd0, bus.req}, {31'd0, tbl[i].ereq});
      check($sformatf("row%0d rdata", i), bus.rdata, tbl[i].erd);
      check($sformatf("row%0d epc_out", i), bus.epc_out, tbl[i].eepc);
    end

    // reset held two cycles with everything asserted
    @(negedge clk);
    drive(1'b1, 5'd12, 1'b1, 32'hFFFFFFFF, 6'h3F, 1'b1, 32'h1000, 1'b1, 6'h3F);
    #2 check("rst_hold1 req", {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    #2 check("rst_hold2 req", {31'd0, bus.req}, 32'd0);

    // first cycle after reset, interrupt lines still high
    @(negedge clk);
    drive(1'b0, 5'd12, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 6'h3F);
    #1;
    check("post_rst req", {31'd0, bus.req}, 32'd0);
    check("post_rst sr", bus.rdata, 32'h0);
    check("post_rst epc_out", bus.epc_out, 32'h0);
    bus.c0addr_m = 5'd13;
    #1 check("post_rst cause", bus.rdata, 32'h0);
    bus.c0addr_m = 5'd14;
    #1 check("post_rst epc", bus.rdata, 32'h0);
    bus.c0addr_m = 5'd15;
    #1 check("post_rst prid", bus.rdata, PRID);

    // IP follows hwint on the next edge
    @(negedge clk);
    bus.c0addr_m = 5'd13;
    #1 check("ip_track cause", bus.rdata, 32'h0000FC00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
